// File: rtl/jk_pkg.sv
// Shared encodings for the JK counter bank: operating modes and per-cell JK actions.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_act_e;

endpackage

// File: rtl/jk_counter_bank_cell.sv
// Single-bit JK cell: falling-edge clock, synchronous active-low reset, update enable.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (jk_act_e'({j_i, k_i}))
      JK_HOLD:   q_d = q_q;
      JK_CLEAR:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  // Reset outranks enable so a low Reset_n always clears the cell.
  always_ff @(negedge clk_i) begin
    if (!rst_ni) begin
      q_q <= 1'b0;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-wide bank of JK cells: JK, up/down count or parallel load.
// Counting (modes 01/10) and Tc exist only when JK_COUNTER_BANK_COUNT_EN is defined.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             Tc
);

  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;

  assign mode = mode_e'(Mode);

`ifdef JK_COUNTER_BANK_COUNT_EN
  logic [WIDTH-1:0] tgl_up;
  logic [WIDTH-1:0] tgl_dn;

  // Ripple-AND toggle chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    tgl_up    = '0;
    tgl_dn    = '0;
    tgl_up[0] = 1'b1;
    tgl_dn[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      tgl_up[i] = tgl_up[i-1] & q[i-1];
      tgl_dn[i] = tgl_dn[i-1] & ~q[i-1];
    end
  end
`endif

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    case (mode)
      MODE_JK: begin
        j_eff = J;
        k_eff = K;
      end
`ifdef JK_COUNTER_BANK_COUNT_EN
      MODE_UP: begin
        j_eff = tgl_up;
        k_eff = tgl_up;
      end
      MODE_DOWN: begin
        j_eff = tgl_dn;
        k_eff = tgl_dn;
      end
`endif
      MODE_LOAD: begin
        j_eff = D;
        k_eff = ~D;
      end
      default: begin
        j_eff = '0;
        k_eff = '0;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .en_i   (En),
      .j_i    (j_eff[g]),
      .k_i    (k_eff[g]),
      .q_o    (q[g])
    );
  end

  assign Q     = q;
  assign Q_bar = ~q;

`ifdef JK_COUNTER_BANK_COUNT_EN
  assign Tc = En & (((mode == MODE_UP) & (&q)) | ((mode == MODE_DOWN) & ~(|q)));
`else
  assign Tc = 1'b0;
`endif

endmodule

// File: tb/tb_jk_counter_bank.sv
// Self-checking bench for jk_counter_bank (WIDTH=4): directed scenarios then random steps vs. a reference model.
// Honours JK_COUNTER_BANK_COUNT_EN the same way the design does.
module tb_jk_counter_bank;

  localparam int unsigned W = 4;
`ifdef JK_COUNTER_BANK_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic         Clk = 1'b1;
  logic         Reset_n;
  logic         En;
  logic [1:0]   Mode;
  logic [W-1:0] J, K, D;
  logic [W-1:0] Q, Q_bar;
  logic         Tc;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mq;  // reference state

  jk_counter_bank #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .En      (En),
    .Mode    (Mode),
    .J       (J),
    .K       (K),
    .D       (D),
    .Q       (Q),
    .Q_bar   (Q_bar),
    .Tc      (Tc)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] model_next(logic [W-1:0] q, logic rst_n, logic en,
                                              logic [1:0] mode, logic [W-1:0] j,
                                              logic [W-1:0] k, logic [W-1:0] d);
    int v;
    logic [W-1:0] r;
    v = int'(q);
    if (!rst_n) return '0;
    if (!en) return q;
    case (mode)
      2'd0: begin
        r = q;
        for (int b = 0; b < W; b++) begin
          if (j[b] && k[b]) r[b] = ~q[b];
          else if (j[b])    r[b] = 1'b1;
          else if (k[b])    r[b] = 1'b0;
        end
        return r;
      end
      2'd1: return COUNT_EN ? W'((v + 1) % 16) : q;
      2'd2: return COUNT_EN ? W'((v + 15) % 16) : q;
      default: return d;
    endcase
  endfunction

  function automatic logic model_tc(logic [W-1:0] q, logic en, logic [1:0] mode);
    if (!COUNT_EN || !en) return 1'b0;
    return (mode == 2'd1 && q == 4'd15) || (mode == 2'd2 && q == 4'd0);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one falling edge, then compare Q, Q_bar and Tc against the model.
  task automatic step(input string tag, input logic rst_n, input logic en, input logic [1:0] mode,
                      input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] d);
    Reset_n = rst_n; En = en; Mode = mode; J = j; K = k; D = d;
    @(negedge Clk);
    mq = model_next(mq, rst_n, en, mode, j, k, d);
    #1;
    chk({tag, ".Q"}, Q, mq);
    chk({tag, ".Qb"}, Q_bar, ~mq);
    chk({tag, ".Tc"}, {3'b000, Tc}, {3'b000, model_tc(mq, en, mode)});
  endtask

  initial begin
    mq = 'x;
    Reset_n = 1'b1; En = 1'b0; Mode = 2'd0; J = '0; K = '0; D = '0;
    #1;

    // Reset beats load; release applies load.
    step("rst", 1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'hA);
    chk("rst_const.Q", Q, 4'h0);
    step("rst_rel", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'hA);
    chk("rst_rel_const.Q", Q, 4'hA);

    // JK mode from 0.
    step("clr", 1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
    step("jk1", 1'b1, 1'b1, 2'd0, 4'b1010, 4'b0110, 4'h0);
    chk("jk1_const.Q", Q, 4'b1010);
    step("jk2", 1'b1, 1'b1, 2'd0, 4'b1010, 4'b0110, 4'h0);
    chk("jk2_const.Q", Q, 4'b1000);

    // Up wrap.
    step("ldE", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'hE);
    step("up1", 1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    step("up2", 1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);

    // Down wrap.
    step("ld1", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'h1);
    step("dn1", 1'b1, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    step("dn2", 1'b1, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);

    // Enable low holds regardless of mode and J/K.
    step("ld7", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'h7);
    for (int n = 0; n < 3; n++) step("hold", 1'b1, 1'b0, 2'd1, 4'hF, 4'hF, 4'h0);
    chk("hold_const.Q", Q, 4'h7);

    // Reset mid-count, then resume from 0.
    step("ld5", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'h5);
    step("rstmid", 1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    step("resume", 1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);

    // A reset pulse between falling edges must not clear state.
    step("ld9", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'h9);
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    step("glitch", 1'b1, 1'b1, 2'd0, 4'h0, 4'h0, 4'h0);
    chk("glitch_const.Q", Q, 4'h9);

    // Count from 3 (holds when counting is compiled out).
    step("ld3", 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 4'h3);
    step("cnt3a", 1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    step("cnt3b", 1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);

    // Randomised steps.
    for (int n = 0; n < 300; n++) begin
      step("rand",
           logic'($urandom_range(0, 19) != 0),
           logic'($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_counter_bank.md
# jk_counter_bank

Parametrised, multi-bit successor to the single-bit JK flip-flop: a WIDTH-wide bank of JK cells sharing one clock and reset. The bank can run as independent JK flip-flops, as a synchronous up or down counter built from JK toggle chains, or as a parallel-load register. It serves as the general-purpose state element and counter for the group's sequential labs, in place of hand-wired JK chains.

## Interface
- WIDTH, 8: number of JK cells and the width of every data port; must be ≥ 2.
- Clk  in  1  clock; state updates on the falling edge.
- Reset_n  in  1  synchronous, active-low reset.
- En  in  1  update enable; low holds all state.
- Mode  in  2  operating mode: 00 JK, 01 count up, 10 count down, 11 load.
- J  in  WIDTH  per-cell J input; used in JK mode only.
- K  in  WIDTH  per-cell K input; used in JK mode only.
- D  in  WIDTH  parallel load data; used in load mode only.
- Q  out  WIDTH  cell state.
- Q_bar  out  WIDTH  bitwise complement of Q, always equal to ~Q.
- Tc  out  1  terminal count, combinational.

## Operation
- One WIDTH-bit state register. Q_bar is derived as ~Q and is never stored separately, so Q and Q_bar cannot disagree.
- Update priority at each falling Clk edge:
  - Reset_n = 0: Q = 0 and Q_bar = all ones, regardless of En, Mode, J, K or D.
  - Otherwise, En = 0: hold.
  - Otherwise, by Mode:
    - 00 (JK): each bit i follows its own {J[i],K[i]}: 00 hold, 01 clear, 10 set, 11 toggle.
    - 01 (up): Q = Q + 1 mod 2^WIDTH. Bit i toggles when Q[i-1:0] is all ones; bit 0 always toggles.
    - 10 (down): Q = Q − 1 mod 2^WIDTH. Bit i toggles when Q[i-1:0] is all zeros; bit 0 always toggles.
    - 11 (load): Q = D.
- J and K are ignored outside mode 00. D is ignored outside mode 11.
- Tc = En & ((Mode == 01 & Q == all ones) | (Mode == 10 & Q == 0)). Tc is 0 in modes 00 and 11.
- Wrap-around requires no special handling: all ones → 0 counting up, 0 → all ones counting down.
- A Mode change takes effect at the next edge with no pipeline flush. Counting continues from the current Q.

## Timing
- Single-edge latency: inputs sampled at a falling edge are reflected on Q and Q_bar immediately after that edge.
- Q and Q_bar are registered. Tc is combinational from Q, Mode and En, and is valid in the same cycle.
- Reset is synchronous only. A Reset_n pulse that does not span a falling edge has no effect.
- Reset asserted mid-count forces Q = 0 at that edge. The first edge after release applies normal behaviour from 0.
- Reset values: Q = 0, Q_bar = all ones. Tc is then 1 only if En = 1 and Mode = 10.

## Configuration
- Macro: JK_COUNTER_BANK_COUNT_EN.
- Defined: modes 01 and 10 count as specified, and Tc is driven as specified.
- Undefined:
  - Modes 01 and 10 behave as hold.
  - Tc is tied to 0.
  - No toggle-chain logic is synthesised.
  - Modes 00 and 11 and reset are unchanged.

## Structure
- Shared package jk_pkg holds the 2-bit mode encodings (MODE_JK, MODE_UP, MODE_DOWN, MODE_LOAD) and the JK action encodings (hold, clear, set, toggle).
- One sub-module, jk_cell: a single-bit JK cell with enable and synchronous active-low reset, instantiated WIDTH times via generate.
- The top level computes each cell's effective J/K from Mode:
  - Count modes: J = K = toggle condition.
  - Load mode: J = D[i], K = ~D[i].
  - JK mode: external J/K pass through.

## Test plan
All scenarios use WIDTH = 4.
- Reset: Reset_n = 0, En = 1, Mode = 11, D = 4'hA for one edge → Q = 4'h0, Q_bar = 4'hF. Then Reset_n = 1 with Mode = 11 held → Q = 4'hA.
- JK mode: from Q = 0, apply J = 4'b1010, K = 4'b0110 → Q = 4'b1010. Repeat the same inputs → Q = 4'b1000.
- Up wrap: load 4'hE, then Mode = 01 → Q = F with Tc = 1, then Q = 0 with Tc = 0.
- Down wrap: load 4'h1, then Mode = 10 → Q = 0 with Tc = 1, then Q = F with Tc = 0.
- Enable and reset priority:
  - En = 0, Mode = 01, J = K = F for 3 edges → Q unchanged and Tc = 0.
  - During an up count at Q = 5, drop Reset_n for one edge → Q = 0. After release, next edge → Q = 1.
- Macro off: Mode = 01 from Q = 3 for 2 edges → Q stays 3 and Tc = 0.
